// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: the stage state
// encoding and the bit layout of the packed control bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipeState_t;

  // Default control bundle width.
  localparam int unsigned CTRL_W_DFLT = 24;

  // Control bundle field LSB offsets and widths (bits [3:0] carry a short immediate).
  localparam int unsigned COND      = 20;
  localparam int unsigned COND_W    = 4;
  localparam int unsigned OPCODE    = 16;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned RD        = 12;
  localparam int unsigned RD_W      = 4;
  localparam int unsigned LINK      = 11;
  localparam int unsigned PREPOST   = 10;
  localparam int unsigned UPDOWN    = 9;
  localparam int unsigned BYTEWORD  = 8;
  localparam int unsigned WRITEBACK = 7;
  localparam int unsigned LOADSTORE = 6;
  localparam int unsigned SBIT      = 5;
  localparam int unsigned IMMOP     = 4;
  localparam int unsigned IMM       = 0;
  localparam int unsigned IMM_W     = 4;

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-high clear.
module pipe_payload_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when load is asserted; otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a skid entry
// so in_ready is fully registered. Flush squashes held instructions.
// Optional macro PIPE_STAGE_PERF_EN adds stall/bubble cycle counters.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned CTRL_W  = CTRL_W_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [CTRL_W-1:0]         out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  localparam int unsigned OPS_W = NUM_OPS * DATA_W;
  localparam int unsigned PAY_W = OPS_W + CTRL_W;

  pipeState_t state;
  pipeState_t stateNext;

  logic             inXfer;
  logic             outXfer;
  logic             mainLoad;
  logic             skidLoad;
  logic [PAY_W-1:0] inPayload;
  logic [PAY_W-1:0] mainD;
  logic [PAY_W-1:0] mainPayload;
  logic [PAY_W-1:0] skidPayload;

  assign inXfer    = in_valid && in_ready;
  assign outXfer   = out_valid && out_ready;
  assign inPayload = {in_ctrl, in_ops};

  // Next state and payload load enables; flush overrides every other event.
  always_comb begin
    stateNext = state;
    mainLoad  = 1'b0;
    skidLoad  = 1'b0;
    mainD     = inPayload;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            mainLoad  = 1'b1;
            stateNext = FULL;
          end
        end
        FULL: begin
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
          end else if (outXfer) begin
            stateNext = EMPTY;
          end else if (inXfer) begin
            skidLoad  = 1'b1;
            stateNext = SKID;
          end
        end
        SKID: begin
          if (outXfer) begin
            mainLoad  = 1'b1;
            mainD     = skidPayload;
            stateNext = FULL;
          end
        end
        default: begin
          stateNext = EMPTY;
        end
      endcase
    end
  end

  // State register with registered handshake outputs derived from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= stateNext;
      out_valid <= (stateNext != EMPTY);
      in_ready  <= (stateNext != SKID);
    end
  end

  pipe_payload_reg #(.WIDTH(PAY_W)) mainReg (
    .clk   (clk),
    .reset (reset),
    .load  (mainLoad),
    .d     (mainD),
    .q     (mainPayload)
  );

  pipe_payload_reg #(.WIDTH(PAY_W)) skidReg (
    .clk   (clk),
    .reset (reset),
    .load  (skidLoad),
    .d     (inPayload),
    .q     (skidPayload)
  );

  assign out_ops  = mainPayload[OPS_W-1:0];
  assign out_ctrl = mainPayload[PAY_W-1:OPS_W];

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall and bubble counters; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (!out_valid && out_ready && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: a two-slot queue model plus
// directed literal checks.
module tb_pipe_stage_skid_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned NO = 2;
  localparam int unsigned CW = 24;
  localparam int unsigned PW = NO * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_ops;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_ops;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_skid_reg #(.DATA_W(DW), .NUM_OPS(NO), .CTRL_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ops    (in_ops),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ops   (out_ops),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nCmp  = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as a FIFO holding at most two instructions.
  logic [PW-1:0] opsQ[$];
  logic [CW-1:0] ctrlQ[$];
  logic [31:0]   mStall;
  logic [31:0]   mBubble;

  // Update the model at each clock edge from the sampled handshake inputs.
  always @(posedge clk or posedge reset) begin
    bit mValid;
    bit mReady;
    if (reset) begin
      opsQ.delete();
      ctrlQ.delete();
      mStall  = 0;
      mBubble = 0;
    end else begin
      mValid = (opsQ.size() > 0);
      mReady = (opsQ.size() < 2);
      if (mValid && !out_ready && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
      if (!mValid && out_ready && mBubble != 32'hFFFF_FFFF) mBubble = mBubble + 1;
      if (flush) begin
        opsQ.delete();
        ctrlQ.delete();
      end else begin
        if (mValid && out_ready) begin
          void'(opsQ.pop_front());
          void'(ctrlQ.pop_front());
        end
        if (in_valid && mReady) begin
          opsQ.push_back(in_ops);
          ctrlQ.push_back(in_ctrl);
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("out_valid", 128'(out_valid), 128'(opsQ.size() > 0));
    check("in_ready", 128'(in_ready), 128'(opsQ.size() < 2));
    if (out_valid && opsQ.size() > 0) begin
      check("out_ops", 128'(out_ops), 128'(opsQ[0]));
      check("out_ctrl", 128'(out_ctrl), 128'(ctrlQ[0]));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 128'(stall_cnt), 128'(mStall));
    check("bubble_cnt", 128'(bubble_cnt), 128'(mBubble));
`endif
  end

  localparam logic [DW-1:0] A_W = 32'hA5A5_0001;
  localparam logic [DW-1:0] B_W = 32'hA5A5_0002;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ops    = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_ops", 128'(out_ops), 128'(0));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(0));

    // Streaming at one instruction per cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("stream_ops", 128'(out_ops), 128'({DW'(2*i), DW'(2*i-1)}));
        check("stream_in_ready", 128'(in_ready), 128'(1));
      end
      in_valid  = 1'b1;
      in_ops    = {DW'(2*i+2), DW'(2*i+1)};
      in_ctrl   = CW'(24'h100 + i);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("stream_last", 128'(out_ops), 128'({DW'(12), DW'(11)}));
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 128'(out_valid), 128'(0));

    // Back-pressure: A then B with downstream stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ops    = {DW'(0), A_W};
    in_ctrl   = CW'(24'hAAA);
    @(negedge clk);
    in_ops  = {DW'(0), B_W};
    in_ctrl = CW'(24'hBBB);
    @(negedge clk);
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_hold_a", 128'(out_ops), 128'({DW'(0), A_W}));
    in_ops  = {DW'(0), 32'hDDDD_DDDD};
    in_ctrl = CW'(24'hDDD);
    @(negedge clk);
    check("bp_still_a", 128'(out_ops), 128'({DW'(0), A_W}));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_then_b", 128'(out_ops), 128'({DW'(0), B_W}));
    check("bp_ready_back", 128'(in_ready), 128'(1));
    @(negedge clk);
    check("bp_empty", 128'(out_valid), 128'(0));

    // Flush in SKID with a simultaneous new input C.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ops    = {DW'(1), A_W};
    @(negedge clk);
    in_ops = {DW'(1), B_W};
    @(negedge clk);
    flush   = 1'b1;
    in_ops  = {DW'(1), 32'hCCCC_CCCC};
    in_ctrl = CW'(24'hCCC);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("flush_no_c", 128'(out_valid), 128'(0));
    end

    // Flush while empty with out_ready toggling.
    for (int i = 0; i < 4; i++) begin
      flush     = (i % 2 == 0);
      out_ready = (i % 2 == 1);
      @(negedge clk);
      check("empty_flush_valid", 128'(out_valid), 128'(0));
    end
    flush = 1'b0;

    // Reset mid-stream while two entries are held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ops    = {DW'(7), DW'(7)};
    @(negedge clk);
    in_ops = {DW'(8), DW'(8)};
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_ops", 128'(out_ops), 128'(0));
    check("midrst_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    reset = 1'b0;

    // Stall for five cycles, then three idle cycles with out_ready high.
    in_valid = 1'b1;
    in_ops   = {DW'(9), DW'(9)};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    check("perf_stall", 128'(stall_cnt), 128'(5));
    check("perf_bubble", 128'(bubble_cnt), 128'(3));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("perf_flush_keep", 128'(stall_cnt), 128'(5));
`endif
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
